// File: rtl/io_timer.sv
// io_timer: memory-mapped down-counting timer with prescaler, auto-reload and level irq
module io_timer #(
  parameter logic [7:0] PSC_RST  = 8'h00,
  parameter logic [7:0] LOAD_RST = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] adrs,
  input  logic [7:0] din,
  output logic [7:0] dout,
  input  logic       rd,
  input  logic       wr,
  output logic       irq,
  output logic [7:0] cnt,
  output logic       tick
);
  logic       en_q, en_d, rl_q, rl_d, ie_q, ie_d, done_q, done_d;
  logic [7:0] psc_q, psc_d, load_q, load_d, count_q, count_d, pc_q, pc_d;
  logic       wr_ctrl, wr_psc, wr_cnt, wr_stat;
  assign wr_ctrl = wr & (adrs == 2'd0);
  assign wr_psc  = wr & (adrs == 2'd1);
  assign wr_cnt  = wr & (adrs == 2'd2);
  assign wr_stat = wr & (adrs == 2'd3);
  assign tick = en_q & (pc_q == psc_q);
  assign irq  = done_q & ie_q;
  assign cnt  = count_q;
  assign dout = ~rd            ? 8'h00 :
                adrs == 2'd0   ? {5'd0, ie_q, rl_q, en_q} :
                adrs == 2'd1   ? psc_q :
                adrs == 2'd2   ? count_q :
                                 {6'd0, en_q, done_q};
  always_comb begin
    en_d    = en_q;
    rl_d    = rl_q;
    ie_d    = ie_q;
    done_d  = done_q;
    psc_d   = psc_q;
    load_d  = load_q;
    count_d = count_q;
    pc_d    = (en_q & ~tick) ? pc_q + 8'd1 : 8'd0;
    // clear is applied before the tick so a same-edge expiry keeps DONE set
    if (wr_stat & din[0]) done_d = 1'b0;
    if (tick & ~wr_cnt) begin
      if (count_q > 8'd1) count_d = count_q - 8'd1;
      else begin
        done_d  = 1'b1;
        count_d = rl_q ? load_q : 8'd0;
        en_d    = rl_q;
      end
    end
    if (wr_ctrl) begin
      en_d = din[0];
      rl_d = din[1];
      ie_d = din[2];
      if (~din[0] | ~en_q) pc_d = 8'd0;
    end
    if (wr_psc) psc_d = din;
    if (wr_cnt) begin
      load_d  = din;
      count_d = din;
      pc_d    = 8'd0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      en_q    <= 1'b0;
      rl_q    <= 1'b0;
      ie_q    <= 1'b0;
      done_q  <= 1'b0;
      psc_q   <= PSC_RST;
      load_q  <= LOAD_RST;
      count_q <= LOAD_RST;
      pc_q    <= 8'd0;
    end else begin
      en_q    <= en_d;
      rl_q    <= rl_d;
      ie_q    <= ie_d;
      done_q  <= done_d;
      psc_q   <= psc_d;
      load_q  <= load_d;
      count_q <= count_d;
      pc_q    <= pc_d;
    end
  end
endmodule

// File: tb/tb_io_timer.sv
// tb_io_timer: directed test-plan sequences plus random bus traffic against a behavioural timer model
module tb_io_timer;
  logic       clk = 1'b0, rst = 1'b1, rd = 1'b0, wr = 1'b0;
  logic [1:0] adrs = 2'd0;
  logic [7:0] din = 8'd0;
  logic [7:0] dout, cnt;
  logic       irq, tick;
  int n_cmp = 0, n_bad = 0;
  bit m_en, m_rl, m_ie, m_done;
  int m_psc, m_load, m_cnt, m_pc;

  io_timer #(.PSC_RST(8'h00), .LOAD_RST(8'h00)) dut (
    .clk(clk), .rst(rst), .adrs(adrs), .din(din), .dout(dout),
    .rd(rd), .wr(wr), .irq(irq), .cnt(cnt), .tick(tick)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [7:0] got, logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void m_reset();
    m_en = 0; m_rl = 0; m_ie = 0; m_done = 0;
    m_psc = 0; m_load = 0; m_cnt = 0; m_pc = 0;
  endfunction

  function automatic bit m_tick();
    return m_en && (m_pc == m_psc);
  endfunction

  function automatic logic [7:0] m_read(int a);
    case (a)
      0: return {5'd0, m_ie, m_rl, m_en};
      1: return m_psc[7:0];
      2: return m_cnt[7:0];
      default: return {6'd0, m_en, m_done};
    endcase
  endfunction

  // one clock edge of the timer rules, applied to the model's registers
  function automatic void m_step(bit w, int a, int d);
    bit t, old_en;
    int n_pc;
    if (rst) begin m_reset(); return; end
    t = m_tick();
    old_en = m_en;
    n_pc = m_en ? (t ? 0 : (m_pc + 1) % 256) : 0;
    if (w && a == 3 && d[0]) m_done = 0;
    if (t && !(w && a == 2)) begin
      if (m_cnt > 1) m_cnt = m_cnt - 1;
      else begin
        m_done = 1;
        if (m_rl) m_cnt = m_load;
        else begin m_cnt = 0; m_en = 0; end
      end
    end
    if (w) case (a)
      0: begin
        if (!d[0] || !old_en) n_pc = 0;
        m_en = d[0]; m_rl = d[1]; m_ie = d[2];
      end
      1: m_psc = d & 255;
      2: begin m_load = d & 255; m_cnt = m_load; n_pc = 0; end
      default: ;
    endcase
    m_pc = n_pc;
  endfunction

  task automatic op(bit w, bit r, int a, int d);
    wr = w; rd = r; adrs = a[1:0]; din = d[7:0];
    #1;
    if (!rst) begin
      check("dout", dout, r ? m_read(a) : 8'h00);
      check("irq", {7'd0, irq}, {7'd0, m_done & m_ie});
      check("tick", {7'd0, tick}, {7'd0, m_tick()});
      check("cnt", cnt, m_cnt[7:0]);
    end
    @(posedge clk);
    m_step(w, a, d);
    #1;
  endtask

  task automatic rdchk(string tag, int a, logic [7:0] exp);
    wr = 0; rd = 1; adrs = a[1:0];
    #1;
    check(tag, dout, exp);
  endtask

  initial begin
    int k;
    m_reset();
    // reset with bus traffic
    @(posedge clk); #1;
    op(1, 1, 0, 8'hff);
    op(1, 1, 2, 8'h55);
    rst = 0;
    check("t1_irq", {7'd0, irq}, 8'd0);
    check("t1_tick", {7'd0, tick}, 8'd0);
    check("t1_cnt", cnt, 8'h00);
    for (int a = 0; a < 4; a++) rdchk("t1_read", a, 8'h00);
    // one-shot
    op(1, 0, 1, 3);
    op(1, 0, 2, 4);
    op(1, 0, 0, 8'h05);
    repeat (15) op(0, 0, 0, 0);
    check("t2_irq_pre", {7'd0, irq}, 8'd0);
    op(0, 0, 0, 0);
    check("t2_irq", {7'd0, irq}, 8'd1);
    check("t2_cnt", cnt, 8'h00);
    rdchk("t2_status", 3, 8'h01);
    repeat (6) op(0, 0, 0, 0);
    check("t2_hold", cnt, 8'h00);
    // auto-reload
    op(1, 0, 3, 1);
    op(1, 0, 1, 0);
    op(1, 0, 2, 2);
    op(1, 0, 0, 8'h03);
    op(0, 0, 0, 0);
    check("t3_cnt1", cnt, 8'h01);
    op(0, 0, 0, 0);
    check("t3_cnt2", cnt, 8'h02);
    rdchk("t3_done", 3, 8'h03);
    op(1, 0, 3, 1);
    rdchk("t3_clr", 3, 8'h02);
    op(0, 0, 0, 0);
    rdchk("t3_reset", 3, 8'h03);
    // clear on the terminal edge loses to the set
    op(0, 0, 0, 0);
    check("t4_cnt", cnt, 8'h01);
    op(1, 0, 3, 1);
    rdchk("t4_done", 3, 8'h03);
    // rewrite while running
    op(1, 0, 0, 0);
    op(1, 0, 3, 1);
    op(1, 0, 1, 1);
    op(1, 0, 2, 10);
    op(1, 0, 0, 1);
    k = 0;
    while (cnt !== 8'd8 && k < 100) begin op(0, 0, 0, 0); k++; end
    check("t5_reach8", cnt, 8'd8);
    op(1, 0, 2, 5);
    check("t5_cnt5", cnt, 8'd5);
    op(0, 0, 0, 0);
    check("t5_hold", cnt, 8'd5);
    op(0, 0, 0, 0);
    check("t5_dec", cnt, 8'd4);
    op(1, 0, 0, 0);
    repeat (5) op(0, 0, 0, 0);
    check("t5_frozen", cnt, 8'd4);
    check("t5_notick", {7'd0, tick}, 8'd0);
    // reset mid-count
    op(1, 0, 1, 0);
    op(1, 0, 2, 3);
    op(1, 0, 0, 8'h07);
    repeat (3) op(0, 0, 0, 0);
    check("t6_cnt", cnt, 8'd3);
    check("t6_irq", {7'd0, irq}, 8'd1);
    rst = 1;
    op(0, 0, 0, 0);
    rst = 0;
    check("t6_irq0", {7'd0, irq}, 8'd0);
    check("t6_cnt0", cnt, 8'd0);
    for (int a = 0; a < 4; a++) rdchk("t6_read", a, 8'h00);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      int a, d;
      bit w;
      a = $urandom_range(0, 3);
      w = ($urandom_range(0, 5) == 0);
      d = (a == 1) ? $urandom_range(0, 3) : (a == 2) ? $urandom_range(0, 6) : $urandom_range(0, 255);
      rst = ($urandom_range(0, 199) == 0);
      op(w, $urandom_range(0, 1) == 1, a, d);
      rst = 0;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
